// File: rtl/output_fgo_controller_pkg.sv
// Shared state encoding and defaults for the output register / FGO controller.
package output_fgo_controller_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // 2'd3 is never entered; the FSM recovers it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_SHOWING   = 2'd2
  } state_t;

endpackage

// File: rtl/output_fgo_controller_vsynch_edge_detect.sv
// Registers vsynch once and flags its falling edge as a one-cycle pulse.
module vsynch_edge_detect (
  input  logic mhz25_clock,
  input  logic reset,
  input  logic vsynch,
  output logic vs_fall
);

  logic vs_q;

  always_ff @(posedge mhz25_clock) begin
    if (reset) vs_q <= 1'b1;
    else       vs_q <= vsynch;
  end

  assign vs_fall = vs_q & ~vsynch;

endmodule

// File: rtl/output_fgo_controller.sv
// Output register plus FGO flag: accepts a character when ready, then holds it
// for a fixed number of whole VGA frames before signalling ready again.
module output_fgo_controller
  import output_fgo_controller_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int DISPLAY_FRAMES  = 2,
  parameter int FRAME_CNT_WIDTH = 4
) (
  input  logic                  mhz25_clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ac_data,
  input  logic                  out_load,
  input  logic                  vsynch,
  input  logic                  ien,
  input  logic                  clear_overrun,
  output logic [DATA_WIDTH-1:0] outr_outdata,
  output logic                  fgo,
  output logic                  output_irq,
  output logic                  overrun
);

  localparam logic [FRAME_CNT_WIDTH-1:0] LAST_FRAME = FRAME_CNT_WIDTH'(DISPLAY_FRAMES - 1);

  state_t                     state;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
  logic                       vs_fall;

  vsynch_edge_detect u_edge (
    .mhz25_clock (mhz25_clock),
    .reset       (reset),
    .vsynch      (vsynch),
    .vs_fall     (vs_fall)
  );

  always_ff @(posedge mhz25_clock) begin
    if (reset) begin
      outr_outdata <= '0;
      fgo          <= 1'b1;
      overrun      <= 1'b0;
      state        <= ST_IDLE;
      frame_cnt    <= '0;
    end else begin
      // A new overrun takes priority over a same-cycle clear.
      if (out_load && !fgo)   overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (out_load) begin
            outr_outdata <= ac_data;
            fgo          <= 1'b0;
            state        <= ST_WAIT_SYNC;
          end
        end
        // The frame in progress at load time is partial and not counted.
        ST_WAIT_SYNC: begin
          if (vs_fall) begin
            frame_cnt <= '0;
            state     <= ST_SHOWING;
          end
        end
        ST_SHOWING: begin
          if (vs_fall) begin
            if (frame_cnt == LAST_FRAME) begin
              state     <= ST_IDLE;
              fgo       <= 1'b1;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          fgo       <= 1'b1;
          frame_cnt <= '0;
        end
      endcase
    end
  end

  assign output_irq = fgo & ien;

endmodule

// File: tb/tb_output_fgo_controller.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic against a frames-remaining reference model.
module tb_output_fgo_controller;

  localparam int DW = 8;
  localparam int DF = 2;

  logic          mhz25_clock = 1'b0;
  logic          reset, out_load, vsynch, ien, clear_overrun;
  logic [DW-1:0] ac_data, outr_outdata;
  logic          fgo, output_irq, overrun;

  output_fgo_controller #(.DATA_WIDTH(DW), .DISPLAY_FRAMES(DF), .FRAME_CNT_WIDTH(4)) dut (
    .mhz25_clock   (mhz25_clock),
    .reset         (reset),
    .ac_data       (ac_data),
    .out_load      (out_load),
    .vsynch        (vsynch),
    .ien           (ien),
    .clear_overrun (clear_overrun),
    .outr_outdata  (outr_outdata),
    .fgo           (fgo),
    .output_irq    (output_irq),
    .overrun       (overrun)
  );

  always #5 mhz25_clock = ~mhz25_clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a display is "edges still needed" rather than states.
  logic [DW-1:0] m_out;
  logic          m_fgo, m_ovr, m_vs_prev;
  int            m_left;

  task automatic model_update();
    logic fall;
    if (reset) begin
      m_out = '0; m_fgo = 1'b1; m_ovr = 1'b0; m_left = 0; m_vs_prev = 1'b1;
    end else begin
      fall = m_vs_prev && !vsynch;
      if (out_load && !m_fgo) m_ovr = 1'b1;
      else if (clear_overrun) m_ovr = 1'b0;
      if (m_fgo) begin
        if (out_load) begin
          m_out = ac_data; m_fgo = 1'b0; m_left = DF + 1;
        end
      end else if (fall) begin
        m_left--;
        if (m_left == 0) m_fgo = 1'b1;
      end
      m_vs_prev = vsynch;
    end
  endtask

  // Apply current inputs across one edge, then sample away from the edge.
  task automatic step();
    model_update();
    @(posedge mhz25_clock);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".outr_outdata"}, 32'(outr_outdata), 32'(m_out));
    check({tag, ".fgo"},          32'(fgo),          32'(m_fgo));
    check({tag, ".overrun"},      32'(overrun),      32'(m_ovr));
    check({tag, ".output_irq"},   32'(output_irq),   32'(m_fgo & ien));
  endtask

  task automatic drive(input logic r, input logic ld, input logic [DW-1:0] ac,
                       input logic vs, input logic ie, input logic clr);
    reset = r; out_load = ld; ac_data = ac; vsynch = vs; ien = ie; clear_overrun = clr;
  endtask

  typedef struct {
    logic          rst, ld;
    logic [DW-1:0] ac;
    logic          vs, ie, clr;
    logic [DW-1:0] e_out;
    logic          e_fgo, e_ovr, e_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic ld, logic [DW-1:0] ac, logic vs, logic ie,
                              logic clr, logic [DW-1:0] eo, logic ef, logic ev, logic ei);
    vec_t v;
    v.rst = rst; v.ld = ld; v.ac = ac; v.vs = vs; v.ie = ie; v.clr = clr;
    v.e_out = eo; v.e_fgo = ef; v.e_ovr = ev; v.e_irq = ei;
    return v;
  endfunction

  initial begin
    drive(1, 0, 8'h00, 1, 1, 0);

    //             rst ld ac     vs ie clr  out    fgo ovr irq
    vecs.push_back(mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 1)); // reset state
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'hA5, 1, 1, 0, 8'hA5, 0, 0, 0)); // accepted load
    vecs.push_back(mk(0, 1, 8'h3C, 1, 1, 0, 8'hA5, 0, 1, 0)); // ignored load -> overrun
    vecs.push_back(mk(0, 0, 8'h3C, 1, 1, 1, 8'hA5, 0, 0, 0)); // clear
    vecs.push_back(mk(0, 1, 8'h3C, 1, 0, 1, 8'hA5, 0, 1, 0)); // set beats clear
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'hA5, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'hA5, 0, 0, 0)); // edge 1
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'hA5, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'hA5, 0, 0, 0)); // edge 2: still busy
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'hA5, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'hA5, 1, 0, 1)); // edge 3: ready
    vecs.push_back(mk(0, 1, 8'h5A, 1, 1, 0, 8'h5A, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h5A, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h5A, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h5A, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h5A, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h77, 0, 1, 0, 8'h5A, 1, 1, 1)); // load on completing edge
    vecs.push_back(mk(0, 1, 8'h77, 1, 1, 0, 8'h77, 0, 1, 0)); // retry accepted
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h77, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h77, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h77, 0, 0, 0)); // SHOWING, count 1
    vecs.push_back(mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 1)); // mid-display reset
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].ac, vecs[i].vs, vecs[i].ie, vecs[i].clr);
      step();
      check($sformatf("vec%0d.outr_outdata", i), 32'(outr_outdata), 32'(vecs[i].e_out));
      check($sformatf("vec%0d.fgo", i),          32'(fgo),          32'(vecs[i].e_fgo));
      check($sformatf("vec%0d.overrun", i),      32'(overrun),      32'(vecs[i].e_ovr));
      check($sformatf("vec%0d.output_irq", i),   32'(output_irq),   32'(vecs[i].e_irq));
    end

    // ien toggles output_irq without a clock edge.
    ien = 1'b1; #1;
    check("irq_comb", 32'(output_irq), 32'(1));
    ien = 1'b0; #1;
    check("irq_comb_off", 32'(output_irq), 32'(0));

    // vsynch low through reset, load, and a 200-cycle low hold: none of it counts.
    drive(1, 0, 8'h00, 0, 1, 0); step(); check_model("lowrst");
    drive(0, 1, 8'hC3, 0, 1, 0); step(); check_model("lowload");
    out_load = 1'b0;
    for (int i = 0; i < 200; i++) begin step(); check_model("hold"); end
    check("hold.fgo_busy", 32'(fgo), 32'(0));
    for (int p = 0; p < DF + 1; p++) begin
      check("pulses.busy", 32'(fgo), 32'(0));
      vsynch = 1'b1; step(); check_model("pulses_hi");
      vsynch = 1'b0; step(); check_model("pulses_lo");
    end
    check("pulses.ready", 32'(fgo), 32'(1));
    check("pulses.data",  32'(outr_outdata), 32'(8'hC3));

    // Randomized traffic against the model; vsynch is a low pulse every few cycles.
    begin
      int vs_timer = 0;
      for (int c = 0; c < 4000; c++) begin
        if (vs_timer == 0) begin
          vsynch   = ~vsynch;
          vs_timer = vsynch ? $urandom_range(12, 2) : $urandom_range(4, 1);
        end else vs_timer--;
        reset         = ($urandom_range(499, 0) == 0);
        out_load      = ($urandom_range(7, 0) == 0);
        ac_data       = DW'($urandom);
        ien           = 1'($urandom);
        clear_overrun = ($urandom_range(15, 0) == 0);
        step();
        check_model("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
